// File: rtl/phy_tx_arbiter.sv
// Two-lane byte arbiter: per-lane FIFOs feeding a single registered output stage
// toward the serializer, granted round-robin between non-empty lanes.
module phy_tx_arbiter #(
  parameter int         DEPTH     = 4,
  parameter logic [7:0] IDLE_BYTE = 8'hBC
) (
  input  logic       clk_2f,
  input  logic       reset,
  input  logic [7:0] data_in0,
  input  logic       valid_in0,
  input  logic [7:0] data_in1,
  input  logic       valid_in1,
  input  logic       ready_out,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       lane_out,
  output logic       full0,
  output logic       full1,
  output logic       empty0,
  output logic       empty1,
  output logic       overflow0,
  output logic       overflow1
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_L0   = 2'd1,
    S_L1   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [7:0]      r_data_p1;
  logic            r_lane_p1;
  logic            r_last;

  logic [7:0]      r_mem   [2][DEPTH];
  logic [AW-1:0]   r_wptr  [2];
  logic [AW-1:0]   r_rptr  [2];
  logic [CW-1:0]   r_cnt   [2];
  logic [CW-1:0]   w_cnt_nxt [2];
  logic [1:0]      r_full;
  logic [1:0]      r_empty;
  logic [1:0]      r_ovf;

  logic [1:0]      w_vin;
  logic [7:0]      w_din   [2];
  logic [1:0]      w_pop;
  logic [1:0]      w_wr;
  logic [1:0]      w_drop;
  logic            w_load;
  logic            w_gnt;

  assign w_vin    = {valid_in1, valid_in0};
  assign w_din[0] = data_in0;
  assign w_din[1] = data_in1;

  // Arbitration: the stage only takes a new byte on a cycle the serializer is
  // ready, so an idle stage with ready_out low stays idle and nothing is popped.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_gnt       = r_last;
    w_pop       = 2'b00;
    if (ready_out) begin
      if (!r_empty[0] && !r_empty[1]) begin
        w_load = 1'b1;
        w_gnt  = ~r_last;
      end else if (!r_empty[0]) begin
        w_load = 1'b1;
        w_gnt  = 1'b0;
      end else if (!r_empty[1]) begin
        w_load = 1'b1;
        w_gnt  = 1'b1;
      end
      if (w_load) begin
        w_pop       = w_gnt ? 2'b10 : 2'b01;
        w_state_nxt = w_gnt ? S_L1 : S_L0;
      end else begin
        w_state_nxt = S_IDLE;
      end
    end
  end

  // A full lane still accepts a byte when it is popped in the same cycle.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      w_wr[n]      = w_vin[n] && (!r_full[n] || w_pop[n]);
      w_drop[n]    = w_vin[n] && r_full[n] && !w_pop[n];
      w_cnt_nxt[n] = r_cnt[n];
      if (w_wr[n] && !w_pop[n])
        w_cnt_nxt[n] = r_cnt[n] + CW'(1);
      else if (!w_wr[n] && w_pop[n])
        w_cnt_nxt[n] = r_cnt[n] - CW'(1);
    end
  end

  // FIFO storage -> output stage (p1)
  always_ff @(posedge clk_2f) begin
    for (int n = 0; n < 2; n++) begin
      if (w_wr[n]) r_mem[n][r_wptr[n]] <= w_din[n];
    end
  end

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_data_p1 <= IDLE_BYTE;
      r_lane_p1 <= 1'b0;
      r_last    <= 1'b1;
      r_full    <= 2'b00;
      r_empty   <= 2'b11;
      r_ovf     <= 2'b00;
      for (int n = 0; n < 2; n++) begin
        r_wptr[n] <= '0;
        r_rptr[n] <= '0;
        r_cnt[n]  <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      if (ready_out) begin
        if (w_load) begin
          r_data_p1 <= r_mem[w_gnt][r_rptr[w_gnt]];
          r_lane_p1 <= w_gnt;
          r_last    <= w_gnt;
        end else begin
          r_data_p1 <= IDLE_BYTE;
        end
      end
      for (int n = 0; n < 2; n++) begin
        if (w_wr[n])  r_wptr[n] <= r_wptr[n] + AW'(1);
        if (w_pop[n]) r_rptr[n] <= r_rptr[n] + AW'(1);
        r_cnt[n]   <= w_cnt_nxt[n];
        r_full[n]  <= (w_cnt_nxt[n] == CW'(DEPTH));
        r_empty[n] <= (w_cnt_nxt[n] == '0);
        if (w_drop[n]) r_ovf[n] <= 1'b1;
      end
    end
  end

  assign data_out  = r_data_p1;
  assign valid_out = (r_state != S_IDLE);
  assign lane_out  = r_lane_p1;
  assign full0     = r_full[0];
  assign full1     = r_full[1];
  assign empty0    = r_empty[0];
  assign empty1    = r_empty[1];
  assign overflow0 = r_ovf[0];
  assign overflow1 = r_ovf[1];

endmodule

// File: tb/tb_phy_tx_arbiter.sv
// Bench for phy_tx_arbiter: directed scenarios plus a randomized run, all
// checked against a queue-based model of the lane FIFOs and output stage.
module tb_phy_tx_arbiter;

  localparam int         DEPTH = 4;
  localparam logic [7:0] IDLE  = 8'hBC;

  logic       clk_2f = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in0 = '0, data_in1 = '0;
  logic       valid_in0 = 1'b0, valid_in1 = 1'b0, ready_out = 1'b0;
  logic [7:0] data_out;
  logic       valid_out, lane_out, full0, full1, empty0, empty1, overflow0, overflow1;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] m_data;
  logic       m_valid, m_lane, m_last, m_ovf0, m_ovf1;

  phy_tx_arbiter #(.DEPTH(DEPTH), .IDLE_BYTE(IDLE)) dut (
    .clk_2f(clk_2f), .reset(reset),
    .data_in0(data_in0), .valid_in0(valid_in0),
    .data_in1(data_in1), .valid_in1(valid_in1),
    .ready_out(ready_out),
    .data_out(data_out), .valid_out(valid_out), .lane_out(lane_out),
    .full0(full0), .full1(full1), .empty0(empty0), .empty1(empty1),
    .overflow0(overflow0), .overflow1(overflow1)
  );

  always #5 clk_2f = ~clk_2f;

  function automatic logic [15:0] dut_vec();
    return {data_out, valid_out, lane_out, full1, full0, empty1, empty0, overflow1, overflow0};
  endfunction

  function automatic logic [15:0] mdl_vec();
    logic f1, f0, e1, e0;
    f1 = (q1.size() == DEPTH);
    f0 = (q0.size() == DEPTH);
    e1 = (q1.size() == 0);
    e0 = (q0.size() == 0);
    return {m_data, m_valid, m_lane, f1, f0, e1, e0, m_ovf1, m_ovf0};
  endfunction

  task automatic model_step(input logic r, input logic v0, input logic [7:0] d0,
                            input logic v1, input logic [7:0] d1, input logic rdy);
    int g;
    logic [7:0] b;
    if (r) begin
      q0.delete(); q1.delete();
      m_valid = 1'b0; m_data = IDLE; m_lane = 1'b0; m_last = 1'b1;
      m_ovf0 = 1'b0; m_ovf1 = 1'b0;
    end else begin
      g = -1;
      b = IDLE;
      if (rdy) begin
        if (q0.size() > 0 && q1.size() > 0) g = m_last ? 0 : 1;
        else if (q0.size() > 0) g = 0;
        else if (q1.size() > 0) g = 1;
        if (g == 0) b = q0.pop_front();
        else if (g == 1) b = q1.pop_front();
        if (g >= 0) begin
          m_data = b; m_valid = 1'b1; m_lane = (g == 1); m_last = (g == 1);
        end else begin
          m_valid = 1'b0; m_data = IDLE;
        end
      end
      if (v0) begin
        if (q0.size() < DEPTH) q0.push_back(d0); else m_ovf0 = 1'b1;
      end
      if (v1) begin
        if (q1.size() < DEPTH) q1.push_back(d1); else m_ovf1 = 1'b1;
      end
    end
  endtask

  task automatic cycle(input logic r, input logic v0, input logic [7:0] d0,
                       input logic v1, input logic [7:0] d1, input logic rdy);
    reset = r; valid_in0 = v0; data_in0 = d0; valid_in1 = v1; data_in1 = d1; ready_out = rdy;
    @(posedge clk_2f);
    model_step(r, v0, d0, v1, d1, rdy);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++)
      cycle(1'b1, 1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
    n_cmp++;
    if (dut_vec() !== mdl_vec()) begin
      n_fail++;
      $display("FAIL reset_state: got %h want %h", dut_vec(), mdl_vec());
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'($urandom));
      n_cmp++;
      if ({valid_out, data_out, empty0, empty1} !== {1'b0, 8'hBC, 1'b1, 1'b1}) begin
        n_fail++;
        $display("FAIL idle_after_reset[%0d]: got v=%b d=%h e0=%b e1=%b want v=0 d=bc e0=1 e1=1",
                 i, valid_out, data_out, empty0, empty1);
      end
    end
  endtask

  task automatic test_lane0_stream();
    logic [7:0] bytes [3] = '{8'h24, 8'h81, 8'h09};
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, (i < 3), (i < 3) ? bytes[i] : 8'h00, 1'b0, 8'h00, 1'b1);
      n_cmp++;
      if (i >= 1 && i <= 3) begin
        if ({valid_out, lane_out, data_out} !== {1'b1, 1'b0, bytes[i-1]}) begin
          n_fail++;
          $display("FAIL lane0_stream[%0d]: got v=%b l=%b d=%h want v=1 l=0 d=%h",
                   i, valid_out, lane_out, data_out, bytes[i-1]);
        end
      end else if (valid_out !== 1'b0) begin
        n_fail++;
        $display("FAIL lane0_stream_idle[%0d]: got v=%b want v=0", i, valid_out);
      end
    end
  endtask

  task automatic test_both_lanes();
    logic [9:0] exp [3] = '{{1'b1, 1'b0, 8'h63}, {1'b1, 1'b1, 8'h0D}, {1'b0, 1'b1, 8'hBC}};
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    cycle(1'b0, 1'b1, 8'h63, 1'b1, 8'h0D, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      n_cmp++;
      if ({valid_out, lane_out, data_out} !== exp[i]) begin
        n_fail++;
        $display("FAIL both_lanes[%0d]: got %h want %h", i, {valid_out, lane_out, data_out}, exp[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] b [5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 8'h00, 1'b1, b[i], 1'b0);
      if (i == 3) begin
        n_cmp++;
        if ({full1, overflow1, valid_out} !== 3'b100) begin
          n_fail++;
          $display("FAIL ovf_full_after4: got full1=%b ovf1=%b v=%b want 1 0 0", full1, overflow1, valid_out);
        end
      end
    end
    n_cmp++;
    if ({full1, overflow1, overflow0, valid_out} !== 4'b1100) begin
      n_fail++;
      $display("FAIL ovf_after5: got full1=%b ovf1=%b ovf0=%b v=%b want 1 1 0 0",
               full1, overflow1, overflow0, valid_out);
    end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      n_cmp++;
      if (i < 4) begin
        if ({valid_out, lane_out, data_out, overflow1} !== {1'b1, 1'b1, b[i], 1'b1}) begin
          n_fail++;
          $display("FAIL ovf_drain[%0d]: got v=%b l=%b d=%h o=%b want v=1 l=1 d=%h o=1",
                   i, valid_out, lane_out, data_out, overflow1, b[i]);
        end
      end else if ({valid_out, empty1, overflow1} !== 3'b011) begin
        n_fail++;
        $display("FAIL ovf_drain_end: got v=%b e1=%b o=%b want 0 1 1", valid_out, empty1, overflow1);
      end
    end
  endtask

  task automatic test_ready_toggle();
    logic       exp_lane;
    logic       pv, pl;
    logic [7:0] pd;
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b0, 1'b1, 8'($urandom), 1'b1, 8'($urandom), 1'b0);
    exp_lane = 1'b0;
    for (int i = 0; i < 12; i++) begin
      pv = valid_out; pl = lane_out; pd = data_out;
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, (i % 2 == 0));
      if (i % 2 != 0) begin
        n_cmp++;
        if ({valid_out, lane_out, data_out} !== {pv, pl, pd}) begin
          n_fail++;
          $display("FAIL toggle_hold[%0d]: got v=%b l=%b d=%h want v=%b l=%b d=%h",
                   i, valid_out, lane_out, data_out, pv, pl, pd);
        end
      end else if (pv) begin
        n_cmp++;
        if (pl !== exp_lane) begin
          n_fail++;
          $display("FAIL toggle_alternate[%0d]: accepted lane %b want %b", i, pl, exp_lane);
        end
        exp_lane = ~exp_lane;
      end
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++;
        $display("FAIL toggle_model[%0d]: got %h want %h", i, dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++)
      cycle(1'b0, 1'b1, 8'($urandom), (i < 2), 8'($urandom), 1'b0);
    n_cmp++;
    if ({overflow0, full0, empty1} !== 3'b110) begin
      n_fail++;
      $display("FAIL mid_prefill: got ovf0=%b full0=%b e1=%b want 1 1 0", overflow0, full0, empty1);
    end
    cycle(1'b1, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
    n_cmp++;
    if ({valid_out, empty0, empty1, overflow0, overflow1, full0, data_out} !== {5'b01100, 1'b0, 8'hBC}) begin
      n_fail++;
      $display("FAIL mid_reset: got v=%b e0=%b e1=%b o0=%b o1=%b f0=%b d=%h want 0 1 1 0 0 0 bc",
               valid_out, empty0, empty1, overflow0, overflow1, full0, data_out);
    end
    cycle(1'b0, 1'b1, 8'h5A, 1'b1, 8'hA5, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    n_cmp++;
    if ({valid_out, lane_out, data_out} !== {1'b1, 1'b0, 8'h5A}) begin
      n_fail++;
      $display("FAIL first_after_reset: got v=%b l=%b d=%h want v=1 l=0 d=5a", valid_out, lane_out, data_out);
    end
  endtask

  task automatic test_random();
    logic       r, v0, v1, rdy, pv, pl;
    logic [7:0] pd;
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 600; i++) begin
      r   = ($urandom_range(0, 79) == 0);
      v0  = ($urandom_range(0, 9) < 6);
      v1  = ($urandom_range(0, 9) < 5);
      rdy = ($urandom_range(0, 9) < 6);
      pv = valid_out; pl = lane_out; pd = data_out;
      cycle(r, v0, 8'($urandom), v1, 8'($urandom), rdy);
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++;
        $display("FAIL random_model[%0d]: got %h want %h", i, dut_vec(), mdl_vec());
      end
      if (!r && pv && !rdy) begin
        n_cmp++;
        if ({valid_out, lane_out, data_out} !== {1'b1, pl, pd}) begin
          n_fail++;
          $display("FAIL random_hold[%0d]: got v=%b l=%b d=%h want v=1 l=%b d=%h",
                   i, valid_out, lane_out, data_out, pl, pd);
        end
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_lane0_stream();
    test_both_lanes();
    test_overflow();
    test_ready_toggle();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
